// File: rtl/modulo_registro_ataque.sv
// ============================================================================
// modulo_registro_ataque : debounced shot entry into the 35-cell attack matrix
// Rev 1.0
// ============================================================================
`default_nettype none

module modulo_registro_ataque #(
   parameter int DEB_CYCLES = 250000,
   parameter int CNT_W      = 6
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             btn,
   input  logic             enable,
   input  logic [5:0]       hh2,
   input  logic [34:0]      m_po,
   output logic [34:0]      m_at,
   output logic [34:0]      m_hit,
   output logic [1:0]       result,
   output logic [CNT_W-1:0] shots,
   output logic [CNT_W-1:0] hits,
   output logic             game_over,
   output logic             busy
);

   localparam int c_DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_EVAL     = 2'd1,
      S_UPDATE   = 2'd2,
      S_WAIT_REL = 2'd3
   } state_t;

   state_t               r_state;
   logic                 r_sync1, r_sync2;
   logic                 r_filt, r_filt_d, r_armed;
   logic [c_DEB_W-1:0]   r_deb_cnt;
   logic [34:0]          r_mask;
   logic                 r_valid, r_shot, r_ship;

   logic [2:0]           w_r, w_c;
   logic                 w_valid;
   logic [5:0]           w_lin, w_idx;
   logic [34:0]          w_mask;
   logic                 w_press;

   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign w_r     = hh2[5:3];
   assign w_c     = hh2[2:0];
   assign w_valid = (w_r != 3'd7) && (w_c <= 3'd4);
   assign w_lin   = {1'b0, w_r, 2'b00} + {3'b000, w_r} + {3'b000, w_c};
   assign w_idx   = 6'd34 - w_lin;
   // One-hot cell select; an invalid coordinate selects nothing.
   assign w_mask  = w_valid ? (35'd1 << w_idx) : 35'd0;

   // Only armed once the button has been seen released, so a button held
   // through clr cannot fire until it is let go and pressed again.
   assign w_press   = r_filt & ~r_filt_d & r_armed;
   assign game_over = (m_po != 35'd0) && ((m_po & ~m_hit) == 35'd0);
   assign busy      = (r_state != S_IDLE);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_filt    <= 1'b0;
         r_filt_d  <= 1'b0;
         r_armed   <= 1'b0;
         r_deb_cnt <= '0;
      end else begin
         r_sync1  <= btn;
         r_sync2  <= r_sync1;
         r_filt_d <= r_filt;
         r_armed  <= r_armed | (~r_sync2 & ~r_filt);
         if (r_sync2 != r_filt) begin
            if (r_deb_cnt == c_DEB_LAST) begin
               r_filt    <= r_sync2;
               r_deb_cnt <= '0;
            end else begin
               r_deb_cnt <= r_deb_cnt + 1'b1;
            end
         end else begin
            r_deb_cnt <= '0;
         end
      end
   end

   // Shot decision is captured on entry to EVAL and committed on entry to
   // UPDATE, so results appear on the second edge after the press pulse.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= S_IDLE;
         r_mask  <= '0;
         r_valid <= 1'b0;
         r_shot  <= 1'b0;
         r_ship  <= 1'b0;
         m_at    <= '0;
         m_hit   <= '0;
         result  <= 2'b00;
         shots   <= '0;
         hits    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_press && enable && !game_over) begin
                  r_mask  <= w_mask;
                  r_valid <= w_valid;
                  r_shot  <= |(m_at & w_mask);
                  r_ship  <= |(m_po & w_mask);
                  r_state <= S_EVAL;
               end
            end
            S_EVAL: begin
               if (!r_valid || r_shot) begin
                  result <= 2'b11;
               end else if (r_ship) begin
                  m_at   <= m_at | r_mask;
                  m_hit  <= m_hit | r_mask;
                  result <= 2'b10;
                  shots  <= f_sat_inc(shots);
                  hits   <= f_sat_inc(hits);
               end else begin
                  m_at   <= m_at | r_mask;
                  result <= 2'b01;
                  shots  <= f_sat_inc(shots);
               end
               r_state <= S_UPDATE;
            end
            S_UPDATE: begin
               r_state <= S_WAIT_REL;
            end
            S_WAIT_REL: begin
               if (!r_filt) r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_modulo_registro_ataque.sv
// ============================================================================
// tb_modulo_registro_ataque : randomized bench against a cell-level shot model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_modulo_registro_ataque;

   localparam int CNT_W   = 5;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             clr;
   logic             btn;
   logic             enable;
   logic [5:0]       hh2;
   logic [34:0]      m_po;
   logic [34:0]      m_at;
   logic [34:0]      m_hit;
   logic [1:0]       result;
   logic [CNT_W-1:0] shots;
   logic [CNT_W-1:0] hits;
   logic             game_over;
   logic             busy;

   always #5 clk = ~clk;

   modulo_registro_ataque #(.DEB_CYCLES(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .clr(clr), .btn(btn), .enable(enable), .hh2(hh2),
      .m_po(m_po), .m_at(m_at), .m_hit(m_hit), .result(result),
      .shots(shots), .hits(hits), .game_over(game_over), .busy(busy)
   );

   int       n_vec = 0;
   int       n_err = 0;
   bit       mat[7][5];
   bit       mhit[7][5];
   int       mshots, mhits;
   int       mres;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_vec++;
      if (obs !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic logic [34:0] exp_at();
      logic [34:0] v;
      v = '0;
      for (int r = 0; r < 7; r++)
         for (int c = 0; c < 5; c++)
            if (mat[r][c]) v[34-(5*r+c)] = 1'b1;
      return v;
   endfunction

   function automatic logic [34:0] exp_hit();
      logic [34:0] v;
      v = '0;
      for (int r = 0; r < 7; r++)
         for (int c = 0; c < 5; c++)
            if (mhit[r][c]) v[34-(5*r+c)] = 1'b1;
      return v;
   endfunction

   function automatic bit model_go();
      return (m_po != 35'd0) && ((m_po & ~exp_hit()) == 35'd0);
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 7; r++)
         for (int c = 0; c < 5; c++) begin
            mat[r][c]  = 1'b0;
            mhit[r][c] = 1'b0;
         end
      mshots = 0;
      mhits  = 0;
      mres   = 0;
   endtask

   task automatic model_shot(input int r, input int c);
      if (r > 6 || c > 4 || mat[r][c]) begin
         mres = 3;
      end else if (m_po[34-(5*r+c)]) begin
         mat[r][c]  = 1'b1;
         mhit[r][c] = 1'b1;
         mres = 2;
         if (mshots < CNT_MAX) mshots++;
         if (mhits < CNT_MAX) mhits++;
      end else begin
         mat[r][c] = 1'b1;
         mres = 1;
         if (mshots < CNT_MAX) mshots++;
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_m_at"}, m_at, exp_at());
      chk({tag, "_m_hit"}, m_hit, exp_hit());
      chk({tag, "_result"}, result, mres);
      chk({tag, "_shots"}, shots, mshots);
      chk({tag, "_hits"}, hits, mhits);
      chk({tag, "_game_over"}, game_over, model_go());
      chk({tag, "_busy"}, busy, 0);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      cyc(2);
      clr = 1'b0;
      model_reset();
      cyc(6);
   endtask

   // One press/release cycle; optional bounce burst before the stable press.
   task automatic fire(input bit bounce, input int hold);
      int   r, c;
      bit   will, seen, en_save;
      logic [5:0] hh_save;
      r    = int'(hh2[5:3]);
      c    = int'(hh2[2:0]);
      will = enable && !model_go();
      if (bounce)
         for (int k = 0; k < 5; k++) begin
            btn = 1'b1; cyc(2);
            btn = 1'b0; cyc(2);
         end
      btn  = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk);
         seen = busy;
      end
      if (will) begin
         chk("press_busy", seen, 1);
         if (seen) chk("pre_shots", shots, mshots);
         model_shot(r, c);
         if (seen) begin
            hh_save = hh2;
            en_save = enable;
            hh2     = 6'($urandom);
            enable  = 1'($urandom);
            @(negedge clk);
            chk("post_shots", shots, mshots);
            chk("post_result", result, mres);
            hh2    = hh_save;
            enable = en_save;
         end
      end else begin
         chk("drop_busy", seen, 0);
      end
      cyc(hold);
      btn = 1'b0;
      cyc(15);
      check_all("fire");
   endtask

   function automatic logic [34:0] rand_map();
      logic [63:0] t;
      t = {$urandom(), $urandom()} & {$urandom(), $urandom()};
      return t[34:0];
   endfunction

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit seen;
      clr = 1'b1; btn = 1'b0; enable = 1'b1; hh2 = '0; m_po = '0;
      model_reset();
      cyc(3);
      clr = 1'b0;
      cyc(6);
      check_all("reset");

      // Water shot at (2,3).
      m_po = 35'h1; hh2 = {3'd2, 3'd3};
      fire(0, 15);
      chk("water_bit21", m_at[21], 1);

      // Sole ship at (2,3): hit then game over blocks further shots.
      do_clr();
      m_po = 35'd1 << 21; hh2 = {3'd2, 3'd3};
      fire(0, 15);
      chk("hit_game_over", game_over, 1);
      hh2 = {3'd0, 3'd0};
      fire(0, 15);
      chk("frozen_bit34", m_at[34], 0);

      // Repeat and invalid coordinates.
      do_clr();
      m_po = 35'h1; hh2 = {3'd1, 3'd1};
      fire(0, 10);
      fire(0, 10);
      chk("repeat_result", result, 2'b11);
      chk("repeat_shots", shots, 1);
      hh2 = {3'd7, 3'd0};
      fire(0, 10);
      hh2 = {3'd3, 3'd5};
      fire(0, 10);
      chk("invalid_result", result, 2'b11);

      // Bounce followed by a long hold yields a single shot.
      do_clr();
      hh2 = {3'd0, 3'd0};
      fire(1, 100);
      chk("bounce_shots", shots, 1);

      // Disabled press is dropped.
      enable = 1'b0; hh2 = {3'd4, 3'd4};
      fire(0, 10);
      enable = 1'b1;

      // clr during UPDATE, button held across release.
      hh2 = {3'd3, 3'd3};
      btn = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk);
         seen = busy;
      end
      chk("midclr_busy", seen, 1);
      @(negedge clk);
      clr = 1'b1;
      #1;
      model_reset();
      check_all("midclr");
      cyc(2);
      clr = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      chk("held_no_fire", seen, 0);
      chk("held_shots", shots, 0);
      btn = 1'b0;
      cyc(15);
      fire(0, 10);

      // Counter saturation: every cell is a ship.
      do_clr();
      m_po = '1;
      for (int r = 0; r < 7; r++)
         for (int c = 0; c < 5; c++) begin
            hh2 = {3'(r), 3'(c)};
            fire(0, 5);
         end
      chk("sat_shots", shots, CNT_MAX);
      chk("sat_hits", hits, CNT_MAX);
      chk("sat_game_over", game_over, 1);

      // Randomized games.
      do_clr();
      m_po = rand_map();
      for (int i = 0; i < 60; i++) begin
         if (model_go() || (i % 12) == 11) begin
            do_clr();
            m_po = rand_map();
         end
         hh2    = 6'($urandom);
         enable = ($urandom_range(0, 7) != 0);
         fire(1'($urandom), $urandom_range(5, 20));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/modulo_registro_ataque.md
Name: modulo_registro_ataque

Overview:
Shot-entry writer for the game's attack matrix: the block that fills the 35-bit attack map the LED-matrix scanner reads. It accepts a raw button press and the 6-bit coordinate switches, debounces the press and validates the cell. It compares the cell against the 35-bit ship-position map and records shot/hit state, counters and a result code for the 7-segment path. One press produces exactly one matrix write.

Parameters:
DEB_CYCLES, 250000, clk cycles the synchronized button must stay stable before a level change is accepted (use 4 in simulation)
CNT_W, 6, width of the shot and hit counters

Ports:
clk  input  1  system clock
clr  input  1  asynchronous active-high reset, clears all state
btn  input  1  raw fire button, active-high, asynchronous to clk
enable  input  1  1 = attack mode active; presses are ignored when 0
hh2  input  6  coordinate switches: hh2[5:3] = row r (0..6), hh2[2:0] = column c (0..4)
m_po  input  35  ship-position map, bit 34-(5r+c) set = ship at (r,c)
m_at  output  35  attacked-cell mask, same bit mapping
m_hit  output  35  hit-cell mask, subset of m_at
result  output  2  last shot: 00 none, 01 water, 10 hit, 11 invalid or repeated
shots  output  CNT_W  accepted shots, saturating
hits  output  CNT_W  accepted hits, saturating
game_over  output  1  1 when m_po!=0 and (m_po & ~m_hit)==0
busy  output  1  1 in any FSM state other than IDLE

Behaviour:
- Reset, asynchronous on clr high: m_at=0, m_hit=0, result=00, shots=0, hits=0, busy=0, FSM=IDLE, debounce counter=0, filtered button=0.
- game_over is combinational from m_po and m_hit, so it is 0 after reset.
- Input conditioning: btn passes through a 2-FF synchronizer. The filtered level changes only after the synchronized value has differed from it for DEB_CYCLES consecutive clocks; any bounce restarts the count.
- A press pulse is generated for one clk on each 0->1 change of the filtered level.
- Index rule: idx = 34 - (5*r + c), computed at 6-bit width. The coordinate is valid only when r<=6 and c<=4; an invalid coordinate never indexes the masks.
- FSM states:
  - IDLE: on a press pulse with enable=1 and game_over=0, go to EVAL. Otherwise stay; presses arriving under those other conditions are dropped.
  - EVAL: lasts 1 cycle. Latches r, c, validity, the already-shot flag m_at[idx] and the ship flag m_po[idx].
  - UPDATE: lasts 1 cycle.
    - Invalid coordinate or already shot: result=11, masks and counters unchanged.
    - Ship present: set m_at[idx] and m_hit[idx], result=10, shots+1, hits+1.
    - No ship: set m_at[idx], result=01, shots+1.
    - Counters saturate at 2^CNT_W-1.
  - WAIT_REL: stay until the filtered level is 0, then return to IDLE. One held press can never fire twice.
- Latency: outputs update on the 2nd clock edge after the press pulse (pulse cycle t, EVAL t+1, outputs visible from t+2).
- result holds its value until the next UPDATE or clr.
- game_over=1 blocks new shots; masks and counters stay frozen.
- enable dropping mid-sequence does not abort EVAL/UPDATE; the shot in flight completes.
- Changes on m_po or hh2 after EVAL do not affect the shot in flight.
- clr asserted in any state returns everything to reset values immediately. After release the block waits for a fresh debounced press; a button still held at release produces a press only once the filtered level rises from 0.

Test Plan:
- Reset: pulse clr -> all outputs 0 including result=00; shots=0, hits=0, game_over=0 with m_po=0.
- Water shot: m_po=35'h1, hh2={3'd2,3'd3}, clean press -> at t+2 m_at[21]=1, m_hit=0, result=01, shots=1, hits=0.
- Hit then game over: m_po bit 21 only, same coordinate press -> m_hit[21]=1, result=10, hits=1, game_over=1. A further press at (0,0) -> no change, m_at[34]=0.
- Repeat and invalid: shoot (1,1) twice -> second gives result=11, shots stays 1. Then hh2={3'd7,3'd0} -> result=11, masks unchanged.
- Bounce and hold, DEB_CYCLES=4:
  - btn toggling every 2 clocks for 20 clocks, then held high 100 clocks -> exactly one shot, shots=1.
  - Press with enable=0 -> no change.
- Reset mid-operation: assert clr during UPDATE -> all outputs 0 at once. Release with btn held -> no shot until btn goes low then high again.
